junction_car_detector: RTL and testbench
========================================

// Module: junction_car_detector
// PURPOSE
//  Car-sensor front end for the traffic light junction: turns raw road-loop sensor pulses into the D1/D2 demand
//  inputs that the light controller samples, and consumes the controller's 6-bit lightseq to retire cars on green.
//  Keeps a per-road count of waiting cars and asserts demand only while cars wait on a red road.
// PARAMETERS
//  CW              4  width of each waiting-car counter (saturates at 2**CW-1)
//  DEPART_CYCLES   2  consecutive own-green cycles per departing car (>=1)
//  DEBOUNCE_CYCLES 3  consecutive synchronised-high cycles for a valid arrival (DEBOUNCE_EN only, >=1)
// PORTS
//  clock     in   1    system clock, rising edge
//  reset     in   1    asynchronous, active-high
//  sense1    in   1    raw loop sensor, road 1 (asynchronous, high while car present)
//  sense2    in   1    raw loop sensor, road 2
//  lightseq  in   6    controller lights {R1,A1,G1,R2,A2,G2}; only G1=[3], G2=[0] used
//  D1        out  1    road 1 demand to controller (registered)
//  D2        out  1    road 2 demand to controller (registered)
//  count1    out  CW   cars waiting/being served, road 1
//  count2    out  CW   cars waiting/being served, road 2
//  ovf1      out  1    sticky: road 1 arrival lost at saturation
//  ovf2      out  1    sticky: road 2 arrival lost at saturation
// BEHAVIOUR
//  Reset (async): sync flops, edge-detect history, counts, depart timers, ovf, D1, D2 = 0; both FSMs IDLE.
//  Per road n (identical, independent):
//  - senseN -> 2-flop synchroniser -> rising-edge detect (history reg) = one arrival pulse, 1 cycle.
//  - History resets to 0: a sensor held high through reset release yields exactly one arrival.
//  - Latency: senseN high at edge k -> countN/state/DN updated at edge k+2.
//  - Count: +1 on arrival, -1 on departure, unchanged if both in one cycle; never below 0.
//  - Saturation: arrival at 2**CW-1 without departure -> count holds, ovfN <= 1 (cleared only by reset).
//  - Depart timer: counts cycles with own green=1; on reaching DEPART_CYCLES-1, departure if count>0,
//    timer -> 0. Timer forced to 0 whenever own green=0 (partial green time discarded).
//  - FSM (2-bit state reg), evaluated with next count:
//      IDLE    : green -> SERVING; else next count>0 -> WAITING.
//      WAITING : green -> SERVING; else stay.
//      SERVING : green=0 -> WAITING if next count>0, else IDLE; green=1 stay.
//  - DN <= (next state == WAITING); arrivals during SERVING raise count but keep DN=0.
//  - Both green bits set (illegal lightseq): each road independently SERVING; no error flagged.
//  - Amber/red codes are all "not green"; DN may assert during amber.
// CONFIGURATION
//  DEBOUNCE_EN defined: arrival = synchronised sensor high DEBOUNCE_CYCLES consecutive cycles; one pulse per
//    high period, re-armed after >=1 low cycle; adds DEBOUNCE_CYCLES-1 cycles latency; shorter glitches ignored.
//  DEBOUNCE_EN undefined: arrival = raw rising edge of synchronised sensor; any >=1-cycle pulse counts.
// TESTING (defaults unless stated)
//  1. reset; lightseq=6'b001100; sense2 high 2 cycles -> count2=1, D2=1 at 3rd edge after rise; D1=0.
//  2. from 1, lightseq=6'b100001 -> next edge D2=0; after 2 green edges count2=0; lightseq=6'b100100 -> D2=0, IDLE.
//  3. lightseq=6'b100001; 16 sense1 pulses -> count1=15, ovf1=1, D1=1; then reset -> all outputs 0.
//  4. lightseq=6'b001100, count1=1, arrival on departure cycle -> count1 stays 1, D1=0 (SERVING).
//  5. count2=5, D2=1; reset asserted mid-clock -> count2=0, D2=0 immediately, before next edge.
//  6. DEBOUNCE_EN, DEBOUNCE_CYCLES=3: 2-cycle sense1 glitch -> count1=0; 3-cycle pulse -> count1=1.

Source files
------------

// File: rtl/junction_car_detector.sv
// Junction car-sensor front end: synchronises loop sensors, counts waiting cars per road and
// raises D1/D2 demand while cars wait on red. Optional arrival debounce: define DEBOUNCE_EN.
module junction_car_detector #(
    parameter int CW              = 4,
    parameter int DEPART_CYCLES   = 2,
    parameter int DEBOUNCE_CYCLES = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          sense1,
    input  logic          sense2,
    input  logic [5:0]    lightseq,
    output logic          D1,
    output logic          D2,
    output logic [CW-1:0] count1,
    output logic [CW-1:0] count2,
    output logic          ovf1,
    output logic          ovf2
);

    // state   | meaning
    // IDLE    | no cars, road not green
    // WAITING | cars queued on a non-green road, demand asserted
    // SERVING | own green showing, cars departing
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WAITING = 2'd1;
    localparam logic [1:0] SERVING = 2'd2;

    localparam int TW  = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;
    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [TW-1:0] T_LAST  = TW'(DEPART_CYCLES - 1);

    logic [1:0] sense;
    logic [1:0] green;
    logic       unused_lights;

    assign sense         = {sense2, sense1};
    assign green         = {lightseq[0], lightseq[3]};
    assign unused_lights = ^{lightseq[5:4], lightseq[2:1]};

    for (genvar n = 0; n < 2; n++) begin : road
        logic          sync0, sync1;
        logic          arrival, departure;
        logic [CW-1:0] cnt, cnt_next;
        logic          ovf, ovf_set;
        logic [TW-1:0] timer;
        logic [1:0]    state, state_next;
        logic          demand;

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                sync0 <= 1'b0;
                sync1 <= 1'b0;
            end else begin
                sync0 <= sense[n];
                sync1 <= sync0;
            end
        end

`ifdef DEBOUNCE_EN
        localparam logic [DBW-1:0] RUN_LAST = DBW'(DEBOUNCE_CYCLES - 1);
        logic [DBW-1:0] run;
        logic           fired;

        // One pulse per high period, on its DEBOUNCE_CYCLES-th high cycle; re-armed by any low cycle.
        assign arrival = sync1 && !fired && (run == RUN_LAST);

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                run   <= '0;
                fired <= 1'b0;
            end else if (!sync1) begin
                run   <= '0;
                fired <= 1'b0;
            end else if (arrival) begin
                fired <= 1'b1;
            end else if (run != RUN_LAST) begin
                run <= run + 1'b1;
            end
        end
`else
        logic hist;

        always_ff @(posedge clock or posedge reset) begin
            if (reset) hist <= 1'b0;
            else       hist <= sync1;
        end

        assign arrival = sync1 && !hist;
`endif

        assign departure = green[n] && (timer == T_LAST) && (cnt != '0);

        // Partial green time is discarded whenever the road leaves green.
        always_ff @(posedge clock or posedge reset) begin
            if (reset)                timer <= '0;
            else if (!green[n])       timer <= '0;
            else if (timer == T_LAST) timer <= '0;
            else                      timer <= timer + 1'b1;
        end

        always_comb begin
            cnt_next = cnt;
            ovf_set  = 1'b0;
            if (arrival && !departure) begin
                if (cnt == CNT_MAX) ovf_set  = 1'b1;
                else                cnt_next = cnt + 1'b1;
            end else if (departure && !arrival) begin
                cnt_next = cnt - 1'b1;
            end
        end

        always_comb begin
            state_next = state;
            case (state)
                IDLE:    if (green[n])              state_next = SERVING;
                         else if (cnt_next != '0)   state_next = WAITING;
                WAITING: if (green[n])              state_next = SERVING;
                SERVING: if (!green[n])             state_next = (cnt_next != '0) ? WAITING : IDLE;
                default:                            state_next = IDLE;
            endcase
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                cnt    <= '0;
                ovf    <= 1'b0;
                state  <= IDLE;
                demand <= 1'b0;
            end else begin
                cnt    <= cnt_next;
                ovf    <= ovf | ovf_set;
                state  <= state_next;
                demand <= (state_next == WAITING);
            end
        end
    end

    assign count1 = road[0].cnt;
    assign count2 = road[1].cnt;
    assign ovf1   = road[0].ovf;
    assign ovf2   = road[1].ovf;
    assign D1     = road[0].demand;
    assign D2     = road[1].demand;

endmodule

// File: tb/tb_junction_car_detector.sv
// Randomised bench for junction_car_detector against a queue-style reference model of waiting cars.
module tb_junction_car_detector;

    localparam int CW  = 4;
    localparam int DEP = 2;
    localparam int DB  = 3;
    localparam int BW  = 2 * CW + 4;
    localparam int MAXC = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          sense1 = 1'b0;
    logic          sense2 = 1'b0;
    logic [5:0]    lightseq = 6'b100100;
    logic          D1, D2, ovf1, ovf2;
    logic [CW-1:0] count1, count2;

    junction_car_detector #(.CW(CW), .DEPART_CYCLES(DEP), .DEBOUNCE_CYCLES(DB)) dut (
        .clock(clock), .reset(reset), .sense1(sense1), .sense2(sense2),
        .lightseq(lightseq), .D1(D1), .D2(D2), .count1(count1), .count2(count2),
        .ovf1(ovf1), .ovf2(ovf2)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: sampled sensor history, consecutive green run, waiting cars.
    bit hist [2][16];
    int grun [2];
    int mcnt [2];
    bit movf [2];
    bit mdem [2];

    logic [5:0] codes [6] = '{6'b001100, 6'b100001, 6'b010100, 6'b100010, 6'b100100, 6'b001001};

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            for (int i = 0; i < 16; i++) hist[n][i] = 1'b0;
            grun[n] = 0;
            mcnt[n] = 0;
            movf[n] = 1'b0;
            mdem[n] = 1'b0;
        end
    endtask

    task automatic model_edge();
        bit s, g, arr, dep;
        for (int n = 0; n < 2; n++) begin
            s = (n == 0) ? sense1 : sense2;
            g = (n == 0) ? lightseq[3] : lightseq[0];
            for (int i = 15; i > 0; i--) hist[n][i] = hist[n][i-1];
            hist[n][0] = s;
`ifdef DEBOUNCE_EN
            arr = !hist[n][DB+2];
            for (int i = 2; i <= DB + 1; i++) arr = arr && hist[n][i];
`else
            arr = hist[n][2] && !hist[n][3];
`endif
            // One car leaves every DEP-th consecutive green cycle.
            if (g) grun[n]++;
            else   grun[n] = 0;
            dep = g && (grun[n] % DEP == 0) && (mcnt[n] > 0);
            if (arr && !dep) begin
                if (mcnt[n] == MAXC) movf[n] = 1'b1;
                else                 mcnt[n]++;
            end else if (dep && !arr) begin
                mcnt[n]--;
            end
            mdem[n] = !g && (mcnt[n] > 0);
        end
    endtask

    function automatic logic [BW-1:0] observed();
        return {count1, count2, ovf1, ovf2, D1, D2};
    endfunction

    function automatic logic [BW-1:0] expected();
        return {CW'(mcnt[0]), CW'(mcnt[1]), movf[0], movf[1], mdem[0], mdem[1]};
    endfunction

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check("model", observed(), expected());
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check("reset_state", observed(), '0);
    endtask

    initial begin
        int dur;
        model_reset();
        lightseq = 6'b001100;
        do_reset();

`ifndef DEBOUNCE_EN
        // Road 2 arrival while road 1 is green.
        sense2 = 1'b1; step(); step();
        sense2 = 1'b0; step();
        check("arrival_latency", {count2, D2, D1}, {CW'(1), 1'b1, 1'b0});
        lightseq = 6'b100001; step();
        check("green_drops_demand", {count2, D2}, {CW'(1), 1'b0});
        step();
        check("departure", {count2, D2}, {CW'(0), 1'b0});
        lightseq = 6'b100100; step();
        check("idle_after_serve", {count2, D2}, {CW'(0), 1'b0});
`endif

        // Saturate road 1 while it is red, then async reset mid-cycle.
        lightseq = 6'b100001;
        for (int i = 0; i < 16; i++) begin
            sense1 = 1'b1; repeat (DB) step();
            sense1 = 1'b0; step();
        end
        repeat (DB + 2) step();
        check("saturation", {count1, ovf1, D1}, {CW'(MAXC), 1'b1, 1'b1});
        #3 reset = 1'b1;
        #1 check("async_reset", observed(), '0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;

        dur = 0;
        for (int i = 0; i < 4000; i++) begin
            if (dur == 0) begin
                lightseq = codes[$urandom_range(0, 5)];
                dur = $urandom_range(1, 80);
            end
            dur--;
            if ($urandom_range(0, 2) == 0) sense1 = ~sense1;
            if ($urandom_range(0, 2) == 0) sense2 = ~sense2;
            if ($urandom_range(0, 999) == 0) do_reset();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
